// File: rtl/kt_disp_pkg.sv
// kt_disp_pkg: active-low 7-seg encodings (bit0=a .. bit6=g), anode constants
// and a digit-to-segment helper for the kitchen timer display.
package kt_disp_pkg;
   typedef logic [1:0] digit_idx_t;
   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [3:0] AN_OFF   = 4'hF;

   function automatic logic [6:0] seg_of(input logic [3:0] d);
      return d == 4'd0 ? SEG_0 : d == 4'd1 ? SEG_1 : d == 4'd2 ? SEG_2 :
             d == 4'd3 ? SEG_3 : d == 4'd4 ? SEG_4 : d == 4'd5 ? SEG_5 :
             d == 4'd6 ? SEG_6 : d == 4'd7 ? SEG_7 : d == 4'd8 ? SEG_8 :
             d == 4'd9 ? SEG_9 : SEG_OFF;
   endfunction
endpackage

// File: rtl/bin60_to_bcd.sv
// bin60_to_bcd: combinational 6-bit binary to two BCD digits, flagging values above 59.
module bin60_to_bcd (
   input  logic [5:0] i_bin,
   output logic [3:0] o_tens,
   output logic [3:0] o_ones,
   output logic       o_oor
);
   always_comb begin
      o_tens = i_bin >= 6'd50 ? 4'd5 : i_bin >= 6'd40 ? 4'd4 : i_bin >= 6'd30 ? 4'd3 :
               i_bin >= 6'd20 ? 4'd2 : i_bin >= 6'd10 ? 4'd1 : 4'd0;
      o_ones = 4'(i_bin - 6'({2'b00, o_tens} * 6'd10));
      o_oor  = i_bin > 6'd59;
   end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexes MM:SS onto four common-anode digits with 1 Hz expiry blink.
// Optional LEADING_ZERO_BLANK_EN blanks the minutes-tens digit when it is zero.
module seg_scan_driver
   import kt_disp_pkg::*;
#(
   parameter int SCAN_DIV  = 100_000,
   parameter int BLINK_DIV = 50_000_000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       disp_en,
   input  logic [5:0] minutes,
   input  logic [5:0] seconds,
   input  logic       time_up,
   output logic [6:0] cathode,
   output logic [3:0] AN
);
   localparam int SW = $clog2(SCAN_DIV);
   localparam int BW = $clog2(BLINK_DIV);

   logic [SW-1:0] r_scan;
   logic [BW-1:0] r_bcnt;
   digit_idx_t    r_idx;
   logic [5:0]    r_min, r_sec;
   logic          r_hide;
   logic [6:0]    r_cath;
   logic [3:0]    r_an;

   logic [3:0] w_min_t, w_min_o, w_sec_t, w_sec_o, w_digit, w_an;
   logic       w_min_oor, w_sec_oor, w_tick, w_bwrap, w_hide, w_blank, w_dash;
   logic [6:0] w_cath;

   bin60_to_bcd u_min (.i_bin(r_min), .o_tens(w_min_t), .o_ones(w_min_o), .o_oor(w_min_oor));
   bin60_to_bcd u_sec (.i_bin(r_sec), .o_tens(w_sec_t), .o_ones(w_sec_o), .o_oor(w_sec_oor));

   always_comb begin
      w_tick  = r_scan == SW'(SCAN_DIV - 1);
      w_bwrap = r_bcnt == BW'(BLINK_DIV - 1);
      // Gating with time_up makes the display visible on the very edge after time_up falls
      w_hide  = time_up && r_hide;
      w_digit = r_idx == 2'd0 ? w_sec_o : r_idx == 2'd1 ? w_sec_t :
                r_idx == 2'd2 ? w_min_o : w_min_t;
      w_dash  = r_idx[1] ? w_min_oor : w_sec_oor;
`ifdef LEADING_ZERO_BLANK_EN
      w_blank = r_idx == 2'd3 && w_min_t == 4'd0 && !w_min_oor;
`else
      w_blank = 1'b0;
`endif
      w_an    = (!disp_en || w_hide || w_blank) ? AN_OFF : ~(4'b0001 << r_idx);
      w_cath  = (!disp_en || w_blank) ? SEG_OFF : w_dash ? SEG_DASH : seg_of(w_digit);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_scan <= '0;
         r_idx  <= '0;
         r_min  <= '0;
         r_sec  <= '0;
         r_bcnt <= '0;
         r_hide <= 1'b0;
         r_cath <= SEG_OFF;
         r_an   <= AN_OFF;
      end else begin
         r_scan <= w_tick ? '0 : r_scan + 1'b1;
         if (w_tick) r_idx <= r_idx + 1'b1;
         if (w_tick && r_idx == 2'd3) begin
            r_min <= minutes;
            r_sec <= seconds;
         end
         r_bcnt <= (time_up && !w_bwrap) ? r_bcnt + 1'b1 : '0;
         r_hide <= time_up && (r_hide ^ w_bwrap);
         r_cath <= w_cath;
         r_an   <= w_an;
      end
   end

   assign cathode = r_cath;
   assign AN      = r_an;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed scoreboard bench; stimulus queues per-edge expectations, a monitor pops and checks.
// Honours LEADING_ZERO_BLANK_EN for the minutes-tens slot.
module tb_seg_scan_driver;
   localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S4 = 7'h19, S5 = 7'h12,
                          S9 = 7'h10, SD = 7'h3F, SO = 7'h7F;
`ifdef LEADING_ZERO_BLANK_EN
   localparam logic [3:0] AN3 = 4'hF;
   localparam logic [6:0] C3  = SO;
`else
   localparam logic [3:0] AN3 = 4'h7;
   localparam logic [6:0] C3  = S0;
`endif

   typedef struct {
      logic [3:0] an;
      logic [6:0] cath;
      bit         cc;
      string      nm;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset, disp_en, time_up;
   logic [5:0] minutes, seconds;
   logic [6:0] cathode;
   logic [3:0] AN;
   exp_t       sb[$];
   int         checks = 0;
   int         failures = 0;

   seg_scan_driver #(.SCAN_DIV(4), .BLINK_DIV(16)) dut (
      .clk(clk), .reset(reset), .disp_en(disp_en), .minutes(minutes),
      .seconds(seconds), .time_up(time_up), .cathode(cathode), .AN(AN)
   );

   always #5 clk = ~clk;

   task automatic cyc(input logic [3:0] an, input logic [6:0] c, input bit cc, input string nm);
      exp_t e;
      e.an = an;
      e.cath = c;
      e.cc = cc;
      e.nm = nm;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic slot(input logic [3:0] an, input logic [6:0] c, input bit cc, input string nm);
      repeat (4) cyc(an, c, cc, nm);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (AN !== e.an) begin
               failures++;
               $display("FAIL %s AN actual=%h required=%h", e.nm, AN, e.an);
            end
            if (e.cc) begin
               checks++;
               if (cathode !== e.cath) begin
                  failures++;
                  $display("FAIL %s cathode actual=%h required=%h", e.nm, cathode, e.cath);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; disp_en = 1'b1; time_up = 1'b0; minutes = 6'd5; seconds = 6'd40;
      cyc(4'hF, SO, 1, "reset"); cyc(4'hF, SO, 1, "reset");
      reset = 1'b0;
      slot(4'hE, S0, 1, "f0_s0"); slot(4'hD, S0, 1, "f0_s1"); slot(4'hB, S0, 1, "f0_s2"); slot(AN3, C3, 1, "f0_s3");
      slot(4'hE, S0, 1, "f1_s0"); seconds = 6'd12;
      slot(4'hD, S4, 1, "f1_s1"); slot(4'hB, S5, 1, "f1_s2"); slot(AN3, C3, 1, "f1_s3");
      slot(4'hE, S2, 1, "f2_s0"); slot(4'hD, S1, 1, "f2_s1"); seconds = 6'd62;
      slot(4'hB, S5, 1, "f2_s2"); slot(AN3, C3, 1, "f2_s3");
      slot(4'hE, SD, 1, "f3_dash0"); slot(4'hD, SD, 1, "f3_dash1"); minutes = 6'd63; seconds = 6'd9;
      slot(4'hB, S5, 1, "f3_s2"); slot(AN3, C3, 1, "f3_s3");
      slot(4'hE, S9, 1, "f4_s0"); slot(4'hD, S0, 1, "f4_s1"); minutes = 6'd5; seconds = 6'd40;
      slot(4'hB, SD, 1, "f4_dash2"); slot(4'h7, SD, 1, "f4_dash3");
      time_up = 1'b1;
      slot(4'hE, S0, 1, "blk_vis_s0"); slot(4'hD, S4, 1, "blk_vis_s1"); slot(4'hB, S5, 1, "blk_vis_s2"); slot(AN3, C3, 1, "blk_vis_s3");
      repeat (4) slot(4'hF, SO, 0, "blk_hidden");
      slot(4'hE, S0, 1, "blk_vis2_s0"); slot(4'hD, S4, 1, "blk_vis2_s1"); slot(4'hB, S5, 1, "blk_vis2_s2"); slot(AN3, C3, 1, "blk_vis2_s3");
      slot(4'hF, SO, 0, "blk_hidden2"); slot(4'hF, SO, 0, "blk_hidden2");
      time_up = 1'b0;
      slot(4'hB, S5, 1, "blk_off_s2"); slot(AN3, C3, 1, "blk_off_s3");
      disp_en = 1'b0;
      slot(4'hF, SO, 1, "dis_s0"); slot(4'hF, SO, 1, "dis_s1");
      disp_en = 1'b1;
      slot(4'hB, S5, 1, "en_s2"); slot(AN3, C3, 1, "en_s3");
      slot(4'hE, S0, 1, "pre_rst_s0"); cyc(4'hD, S4, 1, "pre_rst_s1"); cyc(4'hD, S4, 1, "pre_rst_s1");
      reset = 1'b1;
      cyc(4'hF, SO, 1, "mid_reset");
      reset = 1'b0;
      slot(4'hE, S0, 1, "post_s0"); slot(4'hD, S0, 1, "post_s1"); slot(4'hB, S0, 1, "post_s2"); slot(AN3, C3, 1, "post_s3");
      slot(4'hE, S0, 1, "post2_s0"); slot(4'hD, S4, 1, "post2_s1"); slot(4'hB, S5, 1, "post2_s2"); slot(AN3, C3, 1, "post2_s3");
      @(posedge clk);
      #3;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
